// File: rtl/prod_accum.sv
// ============================================================================
// prod_accum : batches N unsigned multiplier products into a double-buffered,
//              valid/ack-presented accumulator total.
// Optional:    `define PROD_ACCUM_SATURATE_EN clamps the batch to all-ones on carry.
// Revision:    1.0  initial release
// ============================================================================
`default_nettype none

module prod_accum #(
    parameter int ACC_W = 24,
    parameter int N     = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             done,
    input  logic [15:0]      p,
    input  logic             clr,
    output logic [ACC_W-1:0] sum,
    output logic             sum_valid,
    input  logic             sum_ack,
    output logic             sum_ovf,
    output logic [7:0]       count,
    output logic             overrun
);

    localparam logic [0:0] S_EMPTY = 1'b0;
    localparam logic [0:0] S_ACCUM = 1'b1;
    localparam logic [7:0] c_LAST  = 8'(N - 1);

    logic [0:0]       r_state;
    logic             r_done_q;
    logic [ACC_W-1:0] r_acc;
    logic             r_bovf;
    logic [ACC_W-1:0] r_sum;
    logic             r_sum_valid;
    logic             r_sum_ovf;
    logic [7:0]       r_count;
    logic             r_overrun;

    logic             w_cap;
    logic             w_last;
    logic [ACC_W-1:0] w_p_ext;
    logic [ACC_W:0]   w_add;
    logic             w_carry;
    logic [ACC_W-1:0] w_acc_next;

    assign w_cap   = done & ~r_done_q;
    assign w_last  = (N == 1) ? 1'b1 : ((r_state == S_ACCUM) && (r_count == c_LAST));
    assign w_p_ext = ACC_W'(p);
    assign w_add   = {1'b0, r_acc} + {1'b0, w_p_ext};
    assign w_carry = w_add[ACC_W];

`ifdef PROD_ACCUM_SATURATE_EN
    // Once clamped, any further non-zero product carries again, so the clamp holds.
    assign w_acc_next = w_carry ? {ACC_W{1'b1}} : w_add[ACC_W-1:0];
`else
    assign w_acc_next = w_add[ACC_W-1:0];
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_EMPTY;
            r_done_q    <= 1'b1;
            r_acc       <= '0;
            r_bovf      <= 1'b0;
            r_sum       <= '0;
            r_sum_valid <= 1'b0;
            r_sum_ovf   <= 1'b0;
            r_count     <= '0;
            r_overrun   <= 1'b0;
        end else begin
            r_done_q <= done;

            if (sum_ack && r_sum_valid) begin
                r_sum_valid <= 1'b0;
            end

            if (clr) begin
                r_state   <= S_EMPTY;
                r_acc     <= '0;
                r_bovf    <= 1'b0;
                r_count   <= '0;
                r_overrun <= 1'b0;
            end else if (w_cap) begin
                if (w_last) begin
                    // Completion: hand the total to the output register and restart.
                    r_state     <= S_EMPTY;
                    r_sum       <= w_acc_next;
                    r_sum_ovf   <= r_bovf | w_carry;
                    r_sum_valid <= 1'b1;
                    r_acc       <= '0;
                    r_bovf      <= 1'b0;
                    r_count     <= '0;
                    if (r_sum_valid && !sum_ack) begin
                        r_overrun <= 1'b1;
                    end
                end else begin
                    r_state <= S_ACCUM;
                    r_acc   <= w_acc_next;
                    r_bovf  <= r_bovf | w_carry;
                    r_count <= r_count + 8'd1;
                end
            end
        end
    end

    assign sum       = r_sum;
    assign sum_valid = r_sum_valid;
    assign sum_ovf   = r_sum_ovf;
    assign count     = r_count;
    assign overrun   = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_prod_accum.sv
// ============================================================================
// tb_prod_accum : directed self-checking bench for prod_accum (three configs).
// Revision:       1.0  initial release
// ============================================================================
`default_nettype none

module tb_prod_accum;

    logic        clk = 1'b0;
    logic        reset;
    logic        done;
    logic [15:0] p;
    logic        clr;
    logic        sum_ack;

    logic [23:0] a_sum;
    logic        a_valid, a_ovf, a_overrun;
    logic [7:0]  a_count;
    logic [15:0] b_sum;
    logic        b_valid, b_ovf, b_overrun;
    logic [7:0]  b_count;
    logic [23:0] c_sum;
    logic        c_valid, c_ovf, c_overrun;
    logic [7:0]  c_count;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    prod_accum #(.ACC_W(24), .N(4)) u_dut_a (
        .clk(clk), .reset(reset), .done(done), .p(p), .clr(clr),
        .sum(a_sum), .sum_valid(a_valid), .sum_ack(sum_ack), .sum_ovf(a_ovf),
        .count(a_count), .overrun(a_overrun)
    );

    prod_accum #(.ACC_W(16), .N(2)) u_dut_b (
        .clk(clk), .reset(reset), .done(done), .p(p), .clr(clr),
        .sum(b_sum), .sum_valid(b_valid), .sum_ack(sum_ack), .sum_ovf(b_ovf),
        .count(b_count), .overrun(b_overrun)
    );

    prod_accum #(.ACC_W(24), .N(1)) u_dut_c (
        .clk(clk), .reset(reset), .done(done), .p(p), .clr(clr),
        .sum(c_sum), .sum_valid(c_valid), .sum_ack(sum_ack), .sum_ovf(c_ovf),
        .count(c_count), .overrun(c_overrun)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset, then leave one idle cycle so done_q observes done=0.
    task automatic do_reset();
        reset = 1'b1; done = 1'b0; clr = 1'b0; sum_ack = 1'b0; p = '0;
        tick(); tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic pulse(input logic [15:0] pv);
        p    = pv;
        done = 1'b1;
        tick();
        done = 1'b0;
        tick();
    endtask

    logic [15:0] exp_b_sum;

    initial begin
        do_reset();
        check("rst_sum",     32'(a_sum),     32'h0);
        check("rst_valid",   32'(a_valid),   32'h0);
        check("rst_ovf",     32'(a_ovf),     32'h0);
        check("rst_count",   32'(a_count),   32'h0);
        check("rst_overrun", 32'(a_overrun), 32'h0);

        sum_ack = 1'b1;
        tick();
        sum_ack = 1'b0;
        check("ack_idle_valid", 32'(a_valid), 32'h0);

        // Basic 4-product batch.
        pulse(16'h0102);
        pulse(16'h0304);
        pulse(16'h0506);
        check("t1_count3", 32'(a_count), 32'd3);
        check("t1_valid0", 32'(a_valid), 32'h0);
        pulse(16'h0708);
        check("t1_sum",   32'(a_sum),   32'h001014);
        check("t1_valid", 32'(a_valid), 32'h1);
        check("t1_ovf",   32'(a_ovf),   32'h0);
        check("t1_count", 32'(a_count), 32'h0);
        sum_ack = 1'b1;
        tick();
        sum_ack = 1'b0;
        check("t1_ack_valid", 32'(a_valid), 32'h0);
        check("t1_ack_sum",   32'(a_sum),   32'h001014);

        // done held high counts once.
        do_reset();
        p    = 16'h0010;
        done = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
        end
        check("t2_held_count", 32'(a_count), 32'd1);
        done = 1'b0;
        tick();
        pulse(16'h0020);
        check("t2_count2", 32'(a_count), 32'd2);
        pulse(16'h0001);
        pulse(16'h0002);
        check("t2_sum", 32'(a_sum), 32'h000033);

        // Carry out of a 16-bit accumulator.
        do_reset();
        pulse(16'hFFFF);
        pulse(16'hFFFF);
`ifdef PROD_ACCUM_SATURATE_EN
        exp_b_sum = 16'hFFFF;
`else
        exp_b_sum = 16'hFFFE;
`endif
        check("t3_sum",   32'(b_sum),   32'(exp_b_sum));
        check("t3_ovf",   32'(b_ovf),   32'h1);
        check("t3_valid", 32'(b_valid), 32'h1);

        // N=1 overwrite without ack.
        do_reset();
        pulse(16'h0005);
        pulse(16'h0007);
        check("t4_sum",     32'(c_sum),     32'h7);
        check("t4_valid",   32'(c_valid),   32'h1);
        check("t4_overrun", 32'(c_overrun), 32'h1);

        // N=1 completion coincident with ack.
        do_reset();
        pulse(16'h0005);
        p       = 16'h0007;
        done    = 1'b1;
        sum_ack = 1'b1;
        tick();
        done    = 1'b0;
        sum_ack = 1'b0;
        tick();
        check("t4b_sum",     32'(c_sum),     32'h7);
        check("t4b_valid",   32'(c_valid),   32'h1);
        check("t4b_overrun", 32'(c_overrun), 32'h0);

        // clr beats a coincident capture.
        do_reset();
        pulse(16'h0100);
        pulse(16'h0200);
        check("t5_count2", 32'(a_count), 32'd2);
        clr  = 1'b1;
        p    = 16'h0300;
        done = 1'b1;
        tick();
        clr  = 1'b0;
        done = 1'b0;
        tick();
        check("t5_clr_count", 32'(a_count), 32'd0);
        for (int i = 0; i < 4; i++) begin
            pulse(16'h0001);
        end
        check("t5_sum",   32'(a_sum),   32'h000004);
        check("t5_count", 32'(a_count), 32'd0);

        // Reset mid-batch with a pending total, done high across release.
        do_reset();
        for (int i = 1; i <= 6; i++) begin
            pulse(16'(i));
        end
        check("t6_pre_count", 32'(a_count), 32'd2);
        check("t6_pre_valid", 32'(a_valid), 32'h1);
        done  = 1'b1;
        reset = 1'b1;
        tick();
        check("t6_sum",     32'(a_sum),     32'h0);
        check("t6_valid",   32'(a_valid),   32'h0);
        check("t6_ovf",     32'(a_ovf),     32'h0);
        check("t6_count",   32'(a_count),   32'h0);
        check("t6_overrun", 32'(a_overrun), 32'h0);
        reset = 1'b0;
        tick();
        tick();
        check("t6_no_cap", 32'(a_count), 32'h0);
        done = 1'b0;
        tick();
        pulse(16'h0009);
        check("t6_cap_after", 32'(a_count), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
